// File: rtl/data_bus_bridge.sv
// Data-side bridge from the core's req/gnt/rvalid port to on-chip RAM,
// the peripheral req/ack bus, or an error responder for unmapped space.
module data_bus_bridge #(
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter int          RAM_AW      = 14,
  parameter logic [31:0] PER_BASE    = 32'h1000_0000,
  parameter logic [31:0] PER_SIZE    = 32'h0001_0000,
  parameter int          PER_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  input  logic [6:0]        data_wdata_intg_i,
  output logic [31:0]       data_rdata_o,
  output logic [6:0]        data_rdata_intg_o,
  output logic              data_err_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              per_req_o,
  input  logic              per_ack_i,
  output logic              per_we_o,
  output logic [3:0]        per_be_o,
  output logic [31:0]       per_addr_o,
  output logic [31:0]       per_wdata_o,
  input  logic [31:0]       per_rdata_i,
  input  logic              per_err_i
);

  typedef enum logic [2:0] {
    IDLE,
    RAM_RSP,
    PER_WAIT,
    PER_RSP,
    ERR_RSP
  } state_e;

  localparam int CW =
    (PER_TIMEOUT > 1) ? $clog2(PER_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PER_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ram_rd_q, ram_rd_d;
  logic          per_req_q, per_req_d;
  logic          per_we_q, per_we_d;
  logic [3:0]    per_be_q, per_be_d;
  logic [31:0]   per_addr_q, per_addr_d;
  logic [31:0]   per_wdata_q, per_wdata_d;

  logic        ram_hit;
  logic        per_hit;
  logic [31:0] per_off;
  logic        can_gnt;
  logic        gnt;
  logic        unused_intg;

  assign unused_intg = ^data_wdata_intg_i;

  assign per_off = data_addr_i - PER_BASE;
  assign ram_hit =
    data_addr_i[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2];
  assign per_hit = ~ram_hit & (per_off < PER_SIZE);

  assign can_gnt = (state_q == IDLE) | (state_q == RAM_RSP);
  assign gnt     = data_req_i & can_gnt;

  assign data_gnt_o  = gnt;
  assign ram_en_o    = gnt & ram_hit;
  assign ram_we_o    =
    (ram_en_o & data_we_i) ? data_be_i : 4'h0;
  assign ram_addr_o  =
    ram_en_o ? data_addr_i[RAM_AW+1:2] : '0;
  assign ram_wdata_o = ram_en_o ? data_wdata_i : 32'h0;

  // RAM read data arrives in the response cycle itself,
  // so it bypasses the response register.
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = rvalid_q & err_q;
  assign data_rdata_o  =
    !rvalid_q ? 32'h0 :
    ram_rd_q  ? ram_rdata_i : rdata_q;
  assign data_rdata_intg_o = 7'h00;

  assign per_req_o   = per_req_q;
  assign per_we_o    = per_we_q;
  assign per_be_o    = per_be_q;
  assign per_addr_o  = per_addr_q;
  assign per_wdata_o = per_wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rvalid_d    = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    ram_rd_d    = 1'b0;
    per_req_d   = per_req_q;
    per_we_d    = per_we_q;
    per_be_d    = per_be_q;
    per_addr_d  = per_addr_q;
    per_wdata_d = per_wdata_q;
    unique case (state_q)
      IDLE, RAM_RSP: begin
        state_d = IDLE;
        if (gnt) begin
          if (ram_hit) begin
            state_d  = RAM_RSP;
            rvalid_d = 1'b1;
            err_d    = 1'b0;
            rdata_d  = 32'h0;
            ram_rd_d = ~data_we_i;
          end else if (per_hit) begin
            state_d     = PER_WAIT;
            per_req_d   = 1'b1;
            cnt_d       = '0;
            per_we_d    = data_we_i;
            per_be_d    = data_be_i;
            per_addr_d  = per_off;
            per_wdata_d = data_wdata_i;
          end else begin
            state_d  = ERR_RSP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = 32'h0;
          end
        end
      end
      PER_WAIT: begin
        if (per_ack_i) begin
          state_d   = PER_RSP;
          per_req_d = 1'b0;
          rdata_d   = per_we_q ? 32'h0 : per_rdata_i;
          err_d     = per_err_i;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = PER_RSP;
          per_req_d = 1'b0;
          rdata_d   = 32'h0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PER_RSP: begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
      end
      ERR_RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      ram_rd_q    <= 1'b0;
      per_req_q   <= 1'b0;
      per_we_q    <= 1'b0;
      per_be_q    <= 4'h0;
      per_addr_q  <= 32'h0;
      per_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ram_rd_q    <= ram_rd_d;
      per_req_q   <= per_req_d;
      per_we_q    <= per_we_d;
      per_be_q    <= per_be_d;
      per_addr_q  <= per_addr_d;
      per_wdata_q <= per_wdata_d;
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Randomized bench for data_bus_bridge with a word-level RAM
// reference and cycle-count expectations for the peripheral path.
module tb_data_bus_bridge;

  localparam logic [31:0] PER_BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [6:0]  data_wdata_intg_i;
  logic [31:0] data_rdata_o;
  logic [6:0]  data_rdata_intg_o;
  logic        data_err_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [13:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        per_req_o;
  logic        per_ack_i;
  logic        per_we_o;
  logic [3:0]  per_be_o;
  logic [31:0] per_addr_o;
  logic [31:0] per_wdata_o;
  logic [31:0] per_rdata_i;
  logic        per_err_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] tb_ram [16];
  logic [31:0] exp_mem [16];

  data_bus_bridge dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i),
    .data_wdata_intg_i(data_wdata_intg_i),
    .data_rdata_o(data_rdata_o),
    .data_rdata_intg_o(data_rdata_intg_o),
    .data_err_o(data_err_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .per_req_o(per_req_o), .per_ack_i(per_ack_i),
    .per_we_o(per_we_o), .per_be_o(per_be_o),
    .per_addr_o(per_addr_o), .per_wdata_o(per_wdata_o),
    .per_rdata_i(per_rdata_i), .per_err_i(per_err_i)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data returned the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata_i <= tb_ram[ram_addr_o[3:0]];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b])
          tb_ram[ram_addr_o[3:0]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
    end
  end

  task automatic idle_inputs();
    data_req_i = 1'b0;
    data_we_i = 1'b0;
    data_be_i = 4'h0;
    data_addr_i = 32'h0;
    data_wdata_i = 32'h0;
    data_wdata_intg_i = 7'h0;
    per_ack_i = 1'b0;
    per_rdata_i = 32'h0;
    per_err_i = 1'b0;
  endtask

  function automatic logic [31:0] model_access(
    input int idx, input logic we,
    input logic [3:0] be, input logic [31:0] wd);
    if (!we) return exp_mem[idx];
    for (int b = 0; b < 4; b++)
      if (be[b]) exp_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
    return 32'h0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checks++; if (data_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0h exp=0", data_rvalid_o); end
    checks++; if (data_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", data_err_o); end
    checks++; if (data_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", data_rdata_o); end
    checks++; if (per_req_o !== 1'b0) begin failures++; $display("FAIL reset_per_req got=%0h exp=0", per_req_o); end
    checks++; if ({data_gnt_o, ram_en_o, ram_we_o} !== 6'h0) begin failures++; $display("FAIL reset_comb got=%0h exp=0", {data_gnt_o, ram_en_o, ram_we_o}); end
    checks++; if ({per_addr_o, per_be_o, per_we_o} !== 37'h0) begin failures++; $display("FAIL reset_per_regs got=%0h exp=0", {per_addr_o, per_be_o, per_we_o}); end
  endtask

  task automatic test_ram_rw();
    int idx;
    logic we;
    logic [3:0] be;
    logic [31:0] wd, exp_rd;
    for (int n = 0; n < 12; n++) begin
      if (n == 0) begin
        idx = 4; we = 1'b1; be = 4'hF; wd = 32'hDEAD_BEEF;
      end else if (n == 1) begin
        idx = 4; we = 1'b0; be = 4'hF; wd = 32'h0;
      end else begin
        idx = int'($urandom_range(0, 15));
        we = 1'($urandom);
        be = 4'($urandom);
        wd = $urandom;
      end
      @(posedge clk); #1;
      data_req_i = 1'b1; data_we_i = we; data_be_i = be;
      data_addr_i = 32'(idx * 4); data_wdata_i = wd;
      exp_rd = model_access(idx, we, be, wd);
      @(negedge clk);
      checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL ram_gnt got=%0h exp=1", data_gnt_o); end
      checks++; if (ram_en_o !== 1'b1 || ram_addr_o !== 14'(idx)) begin failures++; $display("FAIL ram_addr got=%0h exp=%0h", ram_addr_o, idx); end
      checks++; if (ram_we_o !== (we ? be : 4'h0)) begin failures++; $display("FAIL ram_we got=%0h exp=%0h", ram_we_o, we ? be : 4'h0); end
      @(posedge clk); #1;
      data_req_i = 1'b0;
      @(negedge clk);
      checks++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b0) begin failures++; $display("FAIL ram_rvalid got=%0h/%0h exp=1/0", data_rvalid_o, data_err_o); end
      checks++; if (data_rdata_o !== exp_rd) begin failures++; $display("FAIL ram_rdata got=%0h exp=%0h", data_rdata_o, exp_rd); end
    end
  endtask

  task automatic test_ram_stream(input int n, input bit directed);
    logic [31:0] exp_q [$];
    logic we;
    logic [3:0] be;
    logic [31:0] wd;
    int idx;
    for (int c = 0; c <= n; c++) begin
      @(posedge clk); #1;
      if (c < n) begin
        idx = directed ? c : int'($urandom_range(0, 15));
        we = directed ? 1'b0 : 1'($urandom);
        be = 4'($urandom);
        wd = $urandom;
        data_req_i = 1'b1; data_we_i = we; data_be_i = be;
        data_addr_i = 32'(idx * 4); data_wdata_i = wd;
        exp_q.push_back(model_access(idx, we, be, wd));
      end else begin
        data_req_i = 1'b0;
      end
      @(negedge clk);
      if (c < n) begin
        checks++; if (data_gnt_o !== 1'b1 || ram_addr_o !== 14'(idx)) begin failures++; $display("FAIL stream_gnt c=%0d got=%0h/%0h exp=1/%0h", c, data_gnt_o, ram_addr_o, idx); end
      end
      if (c > 0) begin
        checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== exp_q[c-1]) begin failures++; $display("FAIL stream_rsp c=%0d got=%0h/%0h exp=1/%0h", c, data_rvalid_o, data_rdata_o, exp_q[c-1]); end
      end
    end
    @(negedge clk);
    checks++; if (data_rvalid_o !== 1'b0) begin failures++; $display("FAIL stream_end got=%0h exp=0", data_rvalid_o); end
  endtask

  task automatic per_txn(input logic [31:0] off, input logic we,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] rd, input logic er,
                         input int ack_off);
    int exp_c, got_c, req_cycles;
    logic [31:0] exp_rd;
    logic exp_err;
    req_cycles = (ack_off > 0) ? ack_off : 16;
    exp_c = req_cycles + 2;
    exp_rd = (ack_off > 0 && !we) ? rd : 32'h0;
    exp_err = (ack_off > 0) ? er : 1'b1;
    got_c = 0;
    @(posedge clk); #1;
    data_req_i = 1'b1; data_we_i = we; data_be_i = be;
    data_addr_i = PER_BASE + off; data_wdata_i = wd;
    @(negedge clk);
    checks++; if (data_gnt_o !== 1'b1 || ram_en_o !== 1'b0) begin failures++; $display("FAIL per_gnt got=%0h/%0h exp=1/0", data_gnt_o, ram_en_o); end
    for (int c = 1; c <= 40 && got_c == 0; c++) begin
      @(posedge clk); #1;
      data_req_i = (c < exp_c);
      per_ack_i = (c == ack_off);
      per_rdata_i = rd;
      per_err_i = er;
      @(negedge clk);
      if (c < exp_c) begin
        checks++; if (data_gnt_o !== 1'b0) begin failures++; $display("FAIL per_no_gnt c=%0d got=%0h exp=0", c, data_gnt_o); end
      end
      if (c == 1) begin
        checks++; if (per_addr_o !== off || per_we_o !== we || per_be_o !== be || per_wdata_o !== wd) begin failures++; $display("FAIL per_fields got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", per_addr_o, per_we_o, per_be_o, per_wdata_o, off, we, be, wd); end
      end
      checks++; if (per_req_o !== (c <= req_cycles)) begin failures++; $display("FAIL per_req c=%0d got=%0h exp=%0h", c, per_req_o, c <= req_cycles); end
      if (data_rvalid_o === 1'b1) begin
        got_c = c;
        checks++; if (data_rdata_o !== exp_rd || data_err_o !== exp_err) begin failures++; $display("FAIL per_rsp got=%0h/%0h exp=%0h/%0h", data_rdata_o, data_err_o, exp_rd, exp_err); end
      end
    end
    per_ack_i = 1'b0;
    data_req_i = 1'b0;
    checks++; if (got_c != exp_c) begin failures++; $display("FAIL per_latency got=%0d exp=%0d", got_c, exp_c); end
  endtask

  task automatic test_periph();
    per_txn(32'h40, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 3);
    for (int n = 0; n < 6; n++)
      per_txn($urandom & 32'h0000_FFFC, 1'($urandom), 4'($urandom),
              $urandom, $urandom, 1'($urandom),
              int'($urandom_range(1, 16)));
  endtask

  task automatic test_timeout();
    per_txn(32'h80, 1'b0, 4'hF, 32'h0, $urandom | 32'h1, 1'b0, 0);
    @(posedge clk); #1;
    per_ack_i = 1'b1;
    per_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if (per_req_o !== 1'b0 || data_rvalid_o !== 1'b0) begin failures++; $display("FAIL late_ack got=%0h/%0h exp=0/0", per_req_o, data_rvalid_o); end
    @(posedge clk); #1;
    per_ack_i = 1'b0;
    @(negedge clk);
    checks++; if (data_rvalid_o !== 1'b0) begin failures++; $display("FAIL late_ack_rsp got=%0h exp=0", data_rvalid_o); end
  endtask

  task automatic test_unmapped();
    logic [31:0] a;
    for (int n = 0; n < 5; n++) begin
      a = (n == 0) ? 32'h8000_0000 : (32'h2000_0000 | $urandom);
      @(posedge clk); #1;
      data_req_i = 1'b1; data_we_i = (n == 0) | 1'($urandom);
      data_be_i = 4'hF; data_addr_i = a; data_wdata_i = $urandom;
      @(negedge clk);
      checks++; if (data_gnt_o !== 1'b1 || ram_en_o !== 1'b0 || ram_we_o !== 4'h0) begin failures++; $display("FAIL unm_gnt got=%0h/%0h exp=1/0", data_gnt_o, ram_en_o); end
      @(posedge clk); #1;
      data_req_i = 1'b0;
      @(negedge clk);
      checks++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'h0) begin failures++; $display("FAIL unm_rsp got=%0h/%0h/%0h exp=1/1/0", data_rvalid_o, data_err_o, data_rdata_o); end
      checks++; if (per_req_o !== 1'b0 || ram_en_o !== 1'b0) begin failures++; $display("FAIL unm_side got=%0h/%0h exp=0/0", per_req_o, ram_en_o); end
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    idx = int'($urandom_range(0, 15));
    @(posedge clk); #1;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
    data_addr_i = 32'(idx * 4);
    @(negedge clk);
    checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL b2b_gnt0 got=%0h exp=1", data_gnt_o); end
    @(posedge clk); #1;
    data_addr_i = 32'h9000_0000;
    @(negedge clk);
    checks++; if (data_gnt_o !== 1'b1 || data_rvalid_o !== 1'b1 || data_rdata_o !== exp_mem[idx] || data_err_o !== 1'b0) begin failures++; $display("FAIL b2b_ram got=%0h/%0h/%0h exp=1/1/%0h", data_gnt_o, data_rvalid_o, data_rdata_o, exp_mem[idx]); end
    @(posedge clk); #1;
    data_req_i = 1'b0;
    @(negedge clk);
    checks++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'h0) begin failures++; $display("FAIL b2b_err got=%0h/%0h/%0h exp=1/1/0", data_rvalid_o, data_err_o, data_rdata_o); end
    @(negedge clk);
    checks++; if (data_rvalid_o !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0h exp=0", data_rvalid_o); end
  endtask

  task automatic test_reset_mid();
    int idx;
    @(posedge clk); #1;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
    data_addr_i = PER_BASE + 32'h40;
    @(posedge clk); #1;
    data_req_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (per_req_o !== 1'b1) begin failures++; $display("FAIL mid_pending got=%0h exp=1", per_req_o); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (per_req_o !== 1'b0 || data_rvalid_o !== 1'b0) begin failures++; $display("FAIL mid_abort got=%0h/%0h exp=0/0", per_req_o, data_rvalid_o); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (data_rvalid_o !== 1'b0) begin failures++; $display("FAIL mid_no_rsp got=%0h exp=0", data_rvalid_o); end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (data_rvalid_o !== 1'b0 || per_req_o !== 1'b0) begin failures++; $display("FAIL mid_release got=%0h/%0h exp=0/0", data_rvalid_o, per_req_o); end
    idx = int'($urandom_range(0, 15));
    @(posedge clk); #1;
    data_req_i = 1'b1; data_addr_i = 32'(idx * 4);
    @(negedge clk);
    checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL mid_ram_gnt got=%0h exp=1", data_gnt_o); end
    @(posedge clk); #1;
    data_req_i = 1'b0;
    @(negedge clk);
    checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== exp_mem[idx]) begin failures++; $display("FAIL mid_ram_rsp got=%0h/%0h exp=1/%0h", data_rvalid_o, data_rdata_o, exp_mem[idx]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      tb_ram[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    ram_rdata_i = 32'h0;
    test_reset();
    test_ram_rw();
    test_ram_stream(4, 1'b1);
    test_ram_stream(10, 1'b0);
    test_periph();
    test_timeout();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
